// File: rtl/fmrv32im_axil_arbiter_if.sv
// AXI4-Lite channel bundle shared by the arbiter's two upstream slave ports
// and its downstream master port. "master" drives VALIDs and payloads toward
// a slave; "slave" is the mirror image.
interface fmrv32im_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awcache, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arcache, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awcache, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arcache, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/fmrv32im_axil_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter. One transaction in flight at a
// time, round-robin grant, write preferred over read for the same master.
//
// Handshake rule for every channel: a transfer completes on the rising edge
// where VALID and READY are both high; VALID, once forwarded, stays high
// until READY. VALID/READY are combinational between the granted master and
// the shared slave, so no wait cycles are added inside a transaction.
//
// Optional macro FMRV32IM_ARB_TIMEOUT_EN: adds a cycle counter that aborts a
// hung transaction after TIMEOUT cycles with a SLVERR beat to the master.
module fmrv32im_axil_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    fmrv32im_axil_arbiter_if.slave         S0_AXI,
    fmrv32im_axil_arbiter_if.slave         S1_AXI,
    fmrv32im_axil_arbiter_if.master        M_AXI,
    output logic [1:0]                     ARB_GNT,
    output logic [2:0]                     state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;            // index of granted master
    logic   last_q, last_d;          // master served most recently
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   req0, req1, pick, pick_wr;
    logic   aw_hs, w_hs;
    logic   timed_out;

    // Granted-master request/response-ready signals
    logic   g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    // Outputs toward the shared slave
    logic   m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

    // Responses toward the granted master (zero whenever nothing is granted)
    logic        t_awready, t_wready, t_bvalid, t_arready, t_rvalid;
    logic [1:0]  t_bresp, t_rresp;
    logic [31:0] t_rdata;

    assign req0 = S0_AXI.awvalid | S0_AXI.arvalid;
    assign req1 = S1_AXI.awvalid | S1_AXI.arvalid;

    assign g_awvalid = gnt_q ? S1_AXI.awvalid : S0_AXI.awvalid;
    assign g_wvalid  = gnt_q ? S1_AXI.wvalid  : S0_AXI.wvalid;
    assign g_bready  = gnt_q ? S1_AXI.bready  : S0_AXI.bready;
    assign g_arvalid = gnt_q ? S1_AXI.arvalid : S0_AXI.arvalid;
    assign g_rready  = gnt_q ? S1_AXI.rready  : S0_AXI.rready;

`ifdef FMRV32IM_ARB_TIMEOUT_EN
    logic [31:0] cnt_q;

    // Cycles spent in the current transaction; held at zero while idle and
    // saturating at TIMEOUT so the abort beat stays up until accepted.
    always_ff @(posedge CLK) begin
        if (!RST_N || state_q == IDLE) begin
            cnt_q <= 32'd0;
        end else if (cnt_q != 32'(TIMEOUT)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign timed_out = (state_q != IDLE) && (cnt_q == 32'(TIMEOUT));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timed_out      = 1'b0;
`endif

    // State register and transaction bookkeeping
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state, arbitration and channel steering
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pick      = 1'b0;
        pick_wr   = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        t_awready = 1'b0;
        t_wready  = 1'b0;
        t_bvalid  = 1'b0;
        t_bresp   = 2'b00;
        t_arready = 1'b0;
        t_rvalid  = 1'b0;
        t_rdata   = 32'd0;
        t_rresp   = 2'b00;

        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req0 || req1) begin
                    // On a tie the master not served last wins
                    pick    = (req0 && req1) ? ~last_q : req1;
                    pick_wr = pick ? S1_AXI.awvalid : S0_AXI.awvalid;
                    gnt_d   = pick;
                    state_d = pick_wr ? WR_ADDR : RD_ADDR;
                end
            end

            WR_ADDR: begin
                if (timed_out) begin
                    t_bvalid = 1'b1;
                    t_bresp  = 2'b10;
                    if (g_bready) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end else begin
                    // AW and W finish independently; a finished channel is muted
                    m_awvalid = g_awvalid && !aw_done_q;
                    m_wvalid  = g_wvalid && !w_done_q;
                    t_awready = !aw_done_q && M_AXI.awready;
                    t_wready  = !w_done_q && M_AXI.wready;
                    aw_hs     = m_awvalid && M_AXI.awready;
                    w_hs      = m_wvalid && M_AXI.wready;
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                    if (aw_done_d && w_done_d) begin
                        state_d = WR_RESP;
                    end
                end
            end

            WR_RESP: begin
                if (timed_out) begin
                    t_bvalid = 1'b1;
                    t_bresp  = 2'b10;
                    if (g_bready) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end else begin
                    m_bready = g_bready;
                    t_bvalid = M_AXI.bvalid;
                    t_bresp  = M_AXI.bresp;
                    if (M_AXI.bvalid && g_bready) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end
            end

            RD_ADDR: begin
                if (timed_out) begin
                    t_rvalid = 1'b1;
                    t_rresp  = 2'b10;
                    if (g_rready) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end else begin
                    m_arvalid = g_arvalid;
                    t_arready = M_AXI.arready;
                    if (g_arvalid && M_AXI.arready) begin
                        state_d = RD_DATA;
                    end
                end
            end

            RD_DATA: begin
                if (timed_out) begin
                    t_rvalid = 1'b1;
                    t_rresp  = 2'b10;
                    if (g_rready) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end else begin
                    m_rready = g_rready;
                    t_rvalid = M_AXI.rvalid;
                    t_rdata  = M_AXI.rdata;
                    t_rresp  = M_AXI.rresp;
                    if (M_AXI.rvalid && g_rready) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted no handshake may complete on either side
        if (!RST_N) begin
            m_awvalid = 1'b0;
            m_wvalid  = 1'b0;
            m_bready  = 1'b0;
            m_arvalid = 1'b0;
            m_rready  = 1'b0;
            t_awready = 1'b0;
            t_wready  = 1'b0;
            t_bvalid  = 1'b0;
            t_arready = 1'b0;
            t_rvalid  = 1'b0;
        end
    end

    // Downstream port: handshakes from the FSM, payload from the granted master
    assign M_AXI.awvalid = m_awvalid;
    assign M_AXI.awaddr  = gnt_q ? S1_AXI.awaddr  : S0_AXI.awaddr;
    assign M_AXI.awcache = gnt_q ? S1_AXI.awcache : S0_AXI.awcache;
    assign M_AXI.awprot  = gnt_q ? S1_AXI.awprot  : S0_AXI.awprot;
    assign M_AXI.wvalid  = m_wvalid;
    assign M_AXI.wdata   = gnt_q ? S1_AXI.wdata   : S0_AXI.wdata;
    assign M_AXI.wstrb   = gnt_q ? S1_AXI.wstrb   : S0_AXI.wstrb;
    assign M_AXI.bready  = m_bready;
    assign M_AXI.arvalid = m_arvalid;
    assign M_AXI.araddr  = gnt_q ? S1_AXI.araddr  : S0_AXI.araddr;
    assign M_AXI.arcache = gnt_q ? S1_AXI.arcache : S0_AXI.arcache;
    assign M_AXI.arprot  = gnt_q ? S1_AXI.arprot  : S0_AXI.arprot;
    assign M_AXI.rready  = m_rready;

    // Upstream ports: only the granted master sees responses
    assign S0_AXI.awready = !gnt_q & t_awready;
    assign S0_AXI.wready  = !gnt_q & t_wready;
    assign S0_AXI.bvalid  = !gnt_q & t_bvalid;
    assign S0_AXI.bresp   = gnt_q ? 2'b00 : t_bresp;
    assign S0_AXI.arready = !gnt_q & t_arready;
    assign S0_AXI.rvalid  = !gnt_q & t_rvalid;
    assign S0_AXI.rdata   = gnt_q ? 32'd0 : t_rdata;
    assign S0_AXI.rresp   = gnt_q ? 2'b00 : t_rresp;

    assign S1_AXI.awready = gnt_q & t_awready;
    assign S1_AXI.wready  = gnt_q & t_wready;
    assign S1_AXI.bvalid  = gnt_q & t_bvalid;
    assign S1_AXI.bresp   = gnt_q ? t_bresp : 2'b00;
    assign S1_AXI.arready = gnt_q & t_arready;
    assign S1_AXI.rvalid  = gnt_q & t_rvalid;
    assign S1_AXI.rdata   = gnt_q ? t_rdata : 32'd0;
    assign S1_AXI.rresp   = gnt_q ? t_rresp : 2'b00;

    assign ARB_GNT = (state_q == IDLE) ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);
    assign state_o = state_q;

endmodule

// File: tb/tb_fmrv32im_axil_arbiter.sv
// Bench for fmrv32im_axil_arbiter: two master drivers, a zero-wait slave
// model, and two scoreboards (downstream beats, upstream responses).
module tb_fmrv32im_axil_arbiter;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

    localparam logic [1:0] K_AW = 2'd1;
    localparam logic [1:0] K_W  = 2'd2;
    localparam logic [1:0] K_AR = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // downstream beat: {kind, addr, data}; upstream response: {master, is_read, resp, data}
    logic [49:0] exp_m_q[$];
    logic [35:0] exp_r_q[$];

    fmrv32im_axil_arbiter_if #(.ADDR_WIDTH(16)) s0_if();
    fmrv32im_axil_arbiter_if #(.ADDR_WIDTH(16)) s1_if();
    fmrv32im_axil_arbiter_if #(.ADDR_WIDTH(16)) m_if();

    logic [1:0] arb_gnt;
    logic [2:0] state_o;

    fmrv32im_axil_arbiter #(.ADDR_WIDTH(16), .TIMEOUT(16)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .S0_AXI  (s0_if),
        .S1_AXI  (s1_if),
        .M_AXI   (m_if),
        .ARB_GNT (arb_gnt),
        .state_o (state_o)
    );

    // ---------------- master driver signals ----------------
    logic        aw_v[2];
    logic [15:0] aw_a[2];
    logic        w_v[2];
    logic [31:0] w_d[2];
    logic        b_r[2];
    logic        ar_v[2];
    logic [15:0] ar_a[2];
    logic        r_r[2];

    logic        awready_w[2], wready_w[2], bvalid_w[2], arready_w[2], rvalid_w[2];
    logic [1:0]  bresp_w[2], rresp_w[2];
    logic [31:0] rdata_w[2];

    assign s0_if.awvalid = aw_v[0];
    assign s0_if.awaddr  = aw_a[0];
    assign s0_if.awcache = 4'h0;
    assign s0_if.awprot  = 3'h0;
    assign s0_if.wvalid  = w_v[0];
    assign s0_if.wdata   = w_d[0];
    assign s0_if.wstrb   = 4'hF;
    assign s0_if.bready  = b_r[0];
    assign s0_if.arvalid = ar_v[0];
    assign s0_if.araddr  = ar_a[0];
    assign s0_if.arcache = 4'h0;
    assign s0_if.arprot  = 3'h0;
    assign s0_if.rready  = r_r[0];

    assign s1_if.awvalid = aw_v[1];
    assign s1_if.awaddr  = aw_a[1];
    assign s1_if.awcache = 4'h3;
    assign s1_if.awprot  = 3'h2;
    assign s1_if.wvalid  = w_v[1];
    assign s1_if.wdata   = w_d[1];
    assign s1_if.wstrb   = 4'h3;
    assign s1_if.bready  = b_r[1];
    assign s1_if.arvalid = ar_v[1];
    assign s1_if.araddr  = ar_a[1];
    assign s1_if.arcache = 4'h3;
    assign s1_if.arprot  = 3'h2;
    assign s1_if.rready  = r_r[1];

    assign awready_w[0] = s0_if.awready;  assign awready_w[1] = s1_if.awready;
    assign wready_w[0]  = s0_if.wready;   assign wready_w[1]  = s1_if.wready;
    assign bvalid_w[0]  = s0_if.bvalid;   assign bvalid_w[1]  = s1_if.bvalid;
    assign bresp_w[0]   = s0_if.bresp;    assign bresp_w[1]   = s1_if.bresp;
    assign arready_w[0] = s0_if.arready;  assign arready_w[1] = s1_if.arready;
    assign rvalid_w[0]  = s0_if.rvalid;   assign rvalid_w[1]  = s1_if.rvalid;
    assign rdata_w[0]   = s0_if.rdata;    assign rdata_w[1]   = s1_if.rdata;
    assign rresp_w[0]   = s0_if.rresp;    assign rresp_w[1]   = s1_if.rresp;

    // ---------------- slave model (zero wait, rdata = CAFE_<addr>) ----------------
    logic        slv_ar_en = 1'b1;
    logic        slv_bvalid = 1'b0;
    logic        slv_rvalid = 1'b0;
    logic [31:0] slv_rdata = 32'd0;

    assign m_if.awready = 1'b1;
    assign m_if.wready  = 1'b1;
    assign m_if.arready = slv_ar_en;
    assign m_if.bvalid  = slv_bvalid;
    assign m_if.bresp   = 2'b00;
    assign m_if.rvalid  = slv_rvalid;
    assign m_if.rdata   = slv_rdata;
    assign m_if.rresp   = 2'b00;

    initial begin
        logic rst_seen, aw_hit, w_hit, b_hit, ar_hit, r_hit, have_aw, have_w;
        logic [15:0] ar_addr;
        have_aw = 1'b0;
        have_w  = 1'b0;
        forever begin
            @(negedge clk);
            rst_seen = !rst_n;
            aw_hit   = m_if.awvalid && m_if.awready;
            w_hit    = m_if.wvalid && m_if.wready;
            b_hit    = m_if.bvalid && m_if.bready;
            ar_hit   = m_if.arvalid && m_if.arready;
            r_hit    = m_if.rvalid && m_if.rready;
            ar_addr  = m_if.araddr;
            @(posedge clk); #1;
            if (rst_seen) begin
                have_aw    = 1'b0;
                have_w     = 1'b0;
                slv_bvalid = 1'b0;
                slv_rvalid = 1'b0;
            end else begin
                if (aw_hit) have_aw = 1'b1;
                if (w_hit)  have_w  = 1'b1;
                if (b_hit)  slv_bvalid = 1'b0;
                if (r_hit)  slv_rvalid = 1'b0;
                if (have_aw && have_w && !slv_bvalid) begin
                    slv_bvalid = 1'b1;
                    have_aw    = 1'b0;
                    have_w     = 1'b0;
                end
                if (ar_hit) begin
                    slv_rvalid = 1'b1;
                    slv_rdata  = {16'hCAFE, ar_addr};
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_m(input string name, input logic [49:0] act);
        logic [49:0] e;
        if (exp_m_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected beat %h, expected none", name, act);
        end else begin
            e = exp_m_q.pop_front();
            check(name, 64'(act), 64'(e));
        end
    endtask

    task automatic check_r(input string name, input logic [35:0] act);
        logic [35:0] e;
        if (exp_r_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected response %h, expected none", name, act);
        end else begin
            e = exp_r_q.pop_front();
            check(name, 64'(act), 64'(e));
        end
    endtask

    // Downstream monitor: every handshake the slave sees
    initial begin
        forever begin
            @(negedge clk);
            if (m_if.awvalid && m_if.awready) check_m("m_aw", {K_AW, m_if.awaddr, 32'd0});
            if (m_if.wvalid && m_if.wready)   check_m("m_w", {K_W, 12'd0, m_if.wstrb, m_if.wdata});
            if (m_if.arvalid && m_if.arready) check_m("m_ar", {K_AR, m_if.araddr, 32'd0});
        end
    end

    // Upstream monitor: every response a master accepts
    initial begin
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (bvalid_w[m] && b_r[m]) check_r("b_resp", {m[0], 1'b0, bresp_w[m], 32'd0});
                if (rvalid_w[m] && r_r[m]) check_r("r_resp", {m[0], 1'b1, rresp_w[m], rdata_w[m]});
            end
        end
    end

    // ---------------- driver tasks (entered/left at posedge+1) ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic s_write(input int m, input logic [15:0] addr, input logic [31:0] data,
                           input int w_delay);
        bit aw_hit, w_hit, b_hit, w_done, b_done;
        int cyc;
        w_done = 0;
        b_done = 0;
        cyc    = 0;
        aw_v[m] = 1'b1;
        aw_a[m] = addr;
        b_r[m]  = 1'b1;
        if (w_delay == 0) begin
            w_v[m] = 1'b1;
            w_d[m] = data;
        end
        while (!b_done && cyc < 100) begin
            @(negedge clk);
            aw_hit = aw_v[m] && awready_w[m];
            w_hit  = w_v[m] && wready_w[m];
            b_hit  = b_r[m] && bvalid_w[m];
            tick();
            cyc++;
            if (aw_hit) aw_v[m] = 1'b0;
            if (w_hit) begin
                w_v[m] = 1'b0;
                w_done = 1;
            end
            if (b_hit) begin
                b_r[m] = 1'b0;
                b_done = 1;
            end
            if (!w_done && !w_v[m] && cyc >= w_delay) begin
                w_v[m] = 1'b1;
                w_d[m] = data;
            end
        end
        aw_v[m] = 1'b0;
        w_v[m]  = 1'b0;
        b_r[m]  = 1'b0;
        check("write_done", 64'(b_done), 64'd1);
    endtask

    task automatic s_read(input int m, input logic [15:0] addr);
        bit ar_hit, r_hit, r_done;
        int cyc;
        r_done  = 0;
        cyc     = 0;
        ar_v[m] = 1'b1;
        ar_a[m] = addr;
        r_r[m]  = 1'b1;
        while (!r_done && cyc < 100) begin
            @(negedge clk);
            ar_hit = ar_v[m] && arready_w[m];
            r_hit  = r_r[m] && rvalid_w[m];
            tick();
            cyc++;
            if (ar_hit) ar_v[m] = 1'b0;
            if (r_hit) begin
                r_r[m] = 1'b0;
                r_done = 1;
            end
        end
        ar_v[m] = 1'b0;
        r_r[m]  = 1'b0;
        check("read_done", 64'(r_done), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int m = 0; m < 2; m++) begin
            aw_v[m] = 1'b0; aw_a[m] = '0; w_v[m] = 1'b0; w_d[m] = '0; b_r[m] = 1'b0;
            ar_v[m] = 1'b0; ar_a[m] = '0; r_r[m] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(state_o), 64'(ST_IDLE));
        check("rst_gnt", 64'(arb_gnt), 64'd0);
        check("rst_m_hs", 64'({m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}), 64'd0);
        check("rst_s0_hs", 64'({s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid}), 64'd0);
        check("rst_s1_hs", 64'({s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous reads after reset: S0 first, then S1, twice
        exp_m_q.push_back({K_AR, 16'h0010, 32'd0});
        exp_m_q.push_back({K_AR, 16'h0110, 32'd0});
        exp_r_q.push_back({1'b0, 1'b1, 2'b00, 32'hCAFE_0010});
        exp_r_q.push_back({1'b1, 1'b1, 2'b00, 32'hCAFE_0110});
        fork
            s_read(0, 16'h0010);
            s_read(1, 16'h0110);
        join
        exp_m_q.push_back({K_AR, 16'h0014, 32'd0});
        exp_m_q.push_back({K_AR, 16'h0114, 32'd0});
        exp_r_q.push_back({1'b0, 1'b1, 2'b00, 32'hCAFE_0014});
        exp_r_q.push_back({1'b1, 1'b1, 2'b00, 32'hCAFE_0114});
        fork
            s_read(0, 16'h0014);
            s_read(1, 16'h0114);
        join
        tick();

        // Single write from S0 with grant timing
        exp_m_q.push_back({K_AW, 16'h0004, 32'd0});
        exp_m_q.push_back({K_W, 12'd0, 4'hF, 32'h0000_0005});
        exp_r_q.push_back({1'b0, 1'b0, 2'b00, 32'd0});
        fork
            s_write(0, 16'h0004, 32'h0000_0005, 0);
            begin
                @(negedge clk);
                check("gnt_cycle_n", 64'(arb_gnt), 64'd0);
                check("m_awvalid_n", 64'(m_if.awvalid), 64'd0);
                @(negedge clk);
                check("gnt_cycle_n1", 64'(arb_gnt), 64'd1);
                check("m_awvalid_n1", 64'(m_if.awvalid), 64'd1);
                check("s1_no_ready", 64'({s1_if.awready, s1_if.wready, s1_if.arready}), 64'd0);
            end
        join
        @(negedge clk);
        check("gnt_after_wr", 64'(arb_gnt), 64'd0);
        check("state_after_wr", 64'(state_o), 64'(ST_IDLE));
        tick();

        // S1 with write and read pending together: write first
        exp_m_q.push_back({K_AW, 16'h0108, 32'd0});
        exp_m_q.push_back({K_W, 12'd0, 4'h3, 32'hDEAD_BEEF});
        exp_m_q.push_back({K_AR, 16'h010C, 32'd0});
        exp_r_q.push_back({1'b1, 1'b0, 2'b00, 32'd0});
        exp_r_q.push_back({1'b1, 1'b1, 2'b00, 32'hCAFE_010C});
        fork
            s_write(1, 16'h0108, 32'hDEAD_BEEF, 0);
            s_read(1, 16'h010C);
        join
        tick();

        // Skewed write: W three cycles after AW, AW accepted first
        exp_m_q.push_back({K_AW, 16'h000C, 32'd0});
        exp_m_q.push_back({K_W, 12'd0, 4'hF, 32'h1234_5678});
        exp_r_q.push_back({1'b0, 1'b0, 2'b00, 32'd0});
        fork
            s_write(0, 16'h000C, 32'h1234_5678, 3);
            begin
                repeat (3) @(negedge clk);
                check("skew_state", 64'(state_o), 64'(ST_WR_ADDR));
                check("skew_aw_muted", 64'(m_if.awvalid), 64'd0);
                check("skew_w_idle", 64'(m_if.wvalid), 64'd0);
            end
        join
        tick();

        // Reset while a read response is pending
        exp_m_q.push_back({K_AR, 16'h0020, 32'd0});
        ar_v[0] = 1'b1;
        ar_a[0] = 16'h0020;
        r_r[0]  = 1'b0;
        tick();
        tick();
        ar_v[0] = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("rstmid_state", 64'(state_o), 64'(ST_RD_DATA));
        check("rstmid_slave_rvalid", 64'(m_if.rvalid), 64'd1);
        check("rstmid_s0_rvalid", 64'(s0_if.rvalid), 64'd0);
        check("rstmid_m_rready", 64'(m_if.rready), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", 64'(state_o), 64'(ST_IDLE));
        check("post_rst_gnt", 64'(arb_gnt), 64'd0);
        check("post_rst_m_hs", 64'({m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}), 64'd0);
        check("post_rst_s0_hs", 64'({s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid}), 64'd0);
        tick();

`ifdef FMRV32IM_ARB_TIMEOUT_EN
        // Hung slave: error beat 16 cycles after the grant
        slv_ar_en = 1'b0;
        exp_r_q.push_back({1'b0, 1'b1, 2'b10, 32'd0});
        fork
            s_read(0, 16'h0030);
            begin
                int seen_at;
                seen_at = 0;
                for (int k = 1; k <= 40 && seen_at == 0; k++) begin
                    @(negedge clk);
                    if (s0_if.rvalid) seen_at = k;
                end
                check("timeout_cycle", 64'(seen_at), 64'd18);
            end
        join
        slv_ar_en = 1'b1;
        @(negedge clk);
        check("timeout_idle", 64'(state_o), 64'(ST_IDLE));
        tick();
`endif

        // Final scoreboard drain
        repeat (2) tick();
        check("m_queue_empty", 64'(exp_m_q.size()), 64'd0);
        check("r_queue_empty", 64'(exp_r_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
